// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit/receive path: FSM states,
// the default sync pattern and a small sizing helper.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int                    SYNC_W_DEF   = 4;
    localparam logic [SYNC_W_DEF-1:0] SYNC_PATTERN = 4'b1101;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// Parallel word handshake into the framed serial transmitter.
interface serial_frame_tx_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/tx_shift_reg.sv
// WIDTH-bit load / shift-left register; the MSB is the next data bit to send.
module tx_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] d,
    output logic             msb
);

    logic [WIDTH-1:0] sr_reg;
    logic [WIDTH-1:0] sr_next;

    // Load wins over shift; bit 0 fills with zero as the word moves left.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign sr_next[gi] = load ? d[gi] : (shift_en ? 1'b0 : sr_reg[gi]);
            end else begin : g_upper
                assign sr_next[gi] = load ? d[gi] : (shift_en ? sr_reg[gi-1] : sr_reg[gi]);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_reg <= '0;
        end else begin
            sr_reg <= sr_next;
        end
    end

    assign msb = sr_reg[WIDTH-1];

endmodule

// File: rtl/serial_frame_tx.sv
// Framed parallel-to-serial transmitter: sync pattern, data MSB first,
// even parity, stop bit; the line advances only on bit_en ticks.
module serial_frame_tx #(
    parameter int                WIDTH  = 8,
    parameter int                SYNC_W = serial_pkg::SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC   = serial_pkg::SYNC_PATTERN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_en,
    serial_frame_tx_if.slave  in_if,
    output logic              serial_out,
    output logic              busy,
    output logic              frame_done
);

    import serial_pkg::*;

    localparam int MAX_W = max_int(SYNC_W, WIDTH);
    localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(WIDTH - 1);

    tx_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             parity_reg, parity_next;
    logic             serial_reg, serial_next;
    logic             done_reg, done_next;

    logic              load;
    logic              shift_en;
    logic              word_msb;
    logic [SYNC_W-1:0] sync_shifted;

    // SYNC is a local parameter here, so the SYNC state is named via the package.
    assign sync_shifted = SYNC << cnt_reg;

    tx_shift_reg #(
        .WIDTH(WIDTH)
    ) u_shift (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .shift_en (shift_en),
        .d        (in_if.data_in),
        .msb      (word_msb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            parity_reg <= 1'b0;
            serial_reg <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            parity_reg <= parity_next;
            serial_reg <= serial_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        parity_next = parity_reg;
        serial_next = serial_reg;
        done_next   = 1'b0;
        load        = 1'b0;
        shift_en    = 1'b0;

        case (state_reg)
            IDLE: begin
                // Acceptance edge only latches; the first bit waits for the next tick.
                if (in_if.data_valid) begin
                    load        = 1'b1;
                    parity_next = ^in_if.data_in;
                    cnt_next    = '0;
                    state_next  = serial_pkg::SYNC;
                end
            end
            serial_pkg::SYNC: begin
                if (bit_en) begin
                    serial_next = sync_shifted[SYNC_W-1];
                    if (cnt_reg == SYNC_LAST) begin
                        cnt_next   = '0;
                        state_next = DATA;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            DATA: begin
                if (bit_en) begin
                    serial_next = word_msb;
                    shift_en    = 1'b1;
                    if (cnt_reg == DATA_LAST) begin
                        state_next = PARITY;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_en) begin
                    serial_next = parity_reg;
                    state_next  = STOP;
                end
            end
            STOP: begin
                if (bit_en) begin
                    serial_next = 1'b0;
                    done_next   = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_if.data_ready = (state_reg == IDLE);
    assign busy             = (state_reg != IDLE);
    assign serial_out       = serial_reg;
    assign frame_done       = done_reg;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Randomized and directed bench for serial_frame_tx against a bit-queue frame model.
module tb_serial_frame_tx;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic reset;
    logic bit_en;
    logic serial_out;
    logic busy;
    logic frame_done;

    serial_frame_tx_if #(.WIDTH(WIDTH)) bus ();

    serial_frame_tx #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .bit_en     (bit_en),
        .in_if      (bus),
        .serial_out (serial_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int be_mode      = 0;    // 0 always, 1 every 3rd clock, 2 random, 3 held low

    // Model: a frame is the list of bits still to appear on the line.
    bit               q[$];
    logic             exp_serial = 1'b0;
    logic             exp_done   = 1'b0;
    logic [WIDTH-1:0] cur_word   = '0;
    logic [3:0]       sync_pat   = 4'b1101;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic build_frame(input logic [WIDTH-1:0] w);
        q.delete();
        for (int i = 3; i >= 0; i--) q.push_back(sync_pat[i]);
        for (int i = WIDTH - 1; i >= 0; i--) q.push_back(w[i]);
        q.push_back(bit'($countones(w) % 2));
        q.push_back(1'b0);
        cur_word = w;
    endtask

    task automatic step();
        case (be_mode)
            0:       bit_en = 1'b1;
            1:       bit_en = (cyc % 3 == 0);
            2:       bit_en = 1'($urandom_range(0, 1));
            default: bit_en = 1'b0;
        endcase
        exp_done = 1'b0;
        if (reset) begin
            q.delete();
            exp_serial = 1'b0;
        end else if (q.size() == 0) begin
            if (bus.data_valid) build_frame(bus.data_in);
        end else if (bit_en) begin
            exp_serial = q.pop_front();
            if (q.size() == 0) exp_done = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
        check("serial_out", serial_out, exp_serial);
        check("frame_done", frame_done, exp_done);
        check("data_ready", bus.data_ready, q.size() == 0);
        check("busy", busy, q.size() != 0);
        if (exp_done) $display("[TB] frame word=%02h completed at cycle %0d", cur_word, cyc);
    endtask

    task automatic run_until_idle(input int max_cyc);
        int n;
        n = 0;
        while (q.size() != 0 && n < max_cyc) begin
            step();
            n++;
        end
        check("idle_timeout", q.size(), 0);
    endtask

    task automatic send_capture(input logic [WIDTH-1:0] w, output logic [13:0] bits,
                                output int busy_n, output logic done_last);
        bus.data_valid = 1'b1;
        bus.data_in    = w;
        step();
        bus.data_valid = 1'b0;
        bus.data_in    = WIDTH'($urandom);
        busy_n = busy ? 1 : 0;
        bits   = '0;
        for (int i = 0; i < 14; i++) begin
            step();
            bits = {bits[12:0], serial_out};
            if (busy) busy_n++;
        end
        done_last = frame_done;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w);
        bus.data_valid = 1'b1;
        bus.data_in    = w;
        step();
        bus.data_valid = 1'b0;
    endtask

    initial begin
        logic [13:0] bits;
        logic [17:0] stream;
        logic [3:0]  win;
        logic        done_last;
        logic        held;
        int          busy_n;
        int          det;
        int          ones;
        int          n;

        reset          = 1'b1;
        bit_en         = 1'b1;
        bus.data_valid = 1'b0;
        bus.data_in    = '0;
        step();
        step();
        reset = 1'b0;
        step();
        check("rst_serial", serial_out, 0);
        check("rst_done", frame_done, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", bus.data_ready, 1);

        // One bit per clock, even parity word.
        send_capture(8'hA5, bits, busy_n, done_last);
        check("a5_bits", bits, 14'b1101_10100101_0_0);
        check("a5_busy_cycles", busy_n, 14);
        check("a5_done_last", done_last, 1);
        step();

        // Odd parity word; exactly one sync-pattern match in the line stream.
        send_capture(8'h01, bits, busy_n, done_last);
        check("01_bits", bits, 14'b1101_00000001_1_0);
        stream = {4'b0000, bits};
        det = 0;
        for (int i = 0; i <= 14; i++) begin
            win = stream[i +: 4];
            if (win == 4'b1101) det++;
        end
        check("01_detections", det, 1);
        step();

        // Slow tick with acceptance on a tick edge.
        be_mode = 1;
        while (cyc % 3 != 0) step();
        send_word(8'hFF);
        check("slow_no_bit_on_accept", serial_out, 0);
        ones = 0;
        n    = 0;
        while (q.size() != 0 && n < 200) begin
            step();
            if (serial_out) ones++;
            n++;
        end
        check("slow_high_clocks", ones, 33);
        check("slow_idle_timeout", q.size(), 0);

        // Held valid, back-to-back frames.
        be_mode        = 0;
        step();
        bus.data_valid = 1'b1;
        bus.data_in    = 8'h3C;
        step();
        for (int i = 0; i < 13; i++) begin
            bus.data_in = WIDTH'($urandom);
            step();
            check("hold_ready_low", bus.data_ready, 0);
        end
        bus.data_in = 8'hC3;
        step();
        check("hold_done", frame_done, 1);
        step();
        check("hold_second_accepted", busy, 1);
        bus.data_valid = 1'b0;
        step();
        check("hold_first_sync_bit", serial_out, 1);
        run_until_idle(100);

        // Reset in the middle of the data field.
        send_word(WIDTH'($urandom));
        for (int i = 0; i < 6; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_serial", serial_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", bus.data_ready, 1);
        check("midrst_done", frame_done, 0);
        for (int i = 0; i < 3; i++) step();
        send_word(8'h96);
        run_until_idle(100);

        // Ten-clock stall inside a frame.
        send_word(8'h5A);
        for (int i = 0; i < 8; i++) step();
        held    = serial_out;
        be_mode = 3;
        for (int i = 0; i < 10; i++) begin
            step();
            check("stall_hold", serial_out, held);
        end
        be_mode = 0;
        run_until_idle(100);

        // Random words, random tick pattern, random gaps.
        be_mode = 2;
        for (int f = 0; f < 15; f++) begin
            n = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) step();
            bus.data_valid = 1'b1;
            bus.data_in    = WIDTH'($urandom);
            n = 0;
            while (q.size() == 0 && n < 50) begin
                step();
                n++;
            end
            bus.data_valid = 1'b0;
            run_until_idle(500);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
